// File: rtl/vex_bank_xbar_pkg.sv
// Shared definitions for the Vex bank store: fill FSM encoding and the
// lane-to-bank rotation helper used by the read crossbar.
package vex_bank_xbar_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } vex_state_e;

  // Bank feeding output lane `lane` when the base index sits at bank `rot`.
  function automatic int unsigned lane_bank(input int unsigned rot,
                                            input int unsigned lane,
                                            input int unsigned nch);
    return (rot + lane) & (nch - 32'd1);
  endfunction

endpackage

// File: rtl/vex_bank_xbar_ram.sv
// One bank of the Vex store: simple dual-port RAM, one write port and a
// registered read port. The address MSB selects the ping/pong page.
module vex_bank_ram #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Storage write and registered read.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vex_bank_xbar.sv
// Double-buffered Vex store: streams words into the inactive page while NCH
// channels read elements b..b+NCH-1 of the active page in one 2-cycle access.
module vex_bank_xbar
  import vex_bank_xbar_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NCH    = 4,
  parameter int DEPTH  = 8192
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [$clog2(DEPTH):0]   n_elem_i,
  input  logic                     wr_valid_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  output logic                     wr_ready_o,
  output logic                     fill_done_o,
  output logic                     page_valid_o,
  input  logic                     rd_req_i,
  input  logic [$clog2(DEPTH)-1:0] rd_base_i,
  output logic                     rd_valid_o,
  output logic [NCH*DATA_W-1:0]    chan_data_o,
  output logic [NCH-1:0]           chan_valid_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(NCH);
  localparam int RW = AW - BW;

  vex_state_e state_q, state_d;
  logic [AW:0]   n_clamp_s, n_lat_q, rd_n_q;
  logic [AW-1:0] wr_cnt_q;
  logic          wr_page_q, rd_page_q, page_valid_q, fill_done_q;
  logic          wr_fire_s, wr_last_s, wr_ready_s;

  logic [DATA_W-1:0] bank_rdata_s [NCH];
  logic [NCH-1:0]    lane_ok_s;

  logic              v1_q;
  logic [BW-1:0]     rot1_q;
  logic [NCH-1:0]    ok1_q;
  logic [NCH*DATA_W-1:0] xbar_s;

  logic                  rd_valid_q;
  logic [NCH*DATA_W-1:0] chan_data_q;
  logic [NCH-1:0]        chan_valid_q;

  assign wr_fire_s = (state_q == ST_FILL) && wr_valid_i;
  assign wr_last_s = wr_fire_s && ({1'b0, wr_cnt_q} == (n_lat_q - (AW+1)'(1)));

  // Clamp the requested element count into 1..DEPTH.
  always_comb begin
    n_clamp_s = n_elem_i;
    if (n_elem_i == '0) begin
      n_clamp_s = (AW+1)'(1);
    end else if (n_elem_i > (AW+1)'(DEPTH)) begin
      n_clamp_s = (AW+1)'(DEPTH);
    end else begin
      n_clamp_s = n_elem_i;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_FILL;
        else         state_d = ST_IDLE;
      end
      ST_FILL: begin
        if (wr_last_s) state_d = ST_IDLE;
        else           state_d = ST_FILL;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    wr_ready_s = 1'b0;
    case (state_q)
      ST_FILL: wr_ready_s = 1'b1;
      default: wr_ready_s = 1'b0;
    endcase
  end

  // Fill counter and page bookkeeping; the swap lands on the final write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      n_lat_q      <= (AW+1)'(1);
      rd_n_q       <= '0;
      wr_cnt_q     <= '0;
      wr_page_q    <= 1'b0;
      rd_page_q    <= 1'b0;
      page_valid_q <= 1'b0;
      fill_done_q  <= 1'b0;
    end else begin
      fill_done_q <= wr_last_s;
      if ((state_q == ST_IDLE) && start_i) begin
        n_lat_q  <= n_clamp_s;
        wr_cnt_q <= '0;
      end else if (wr_fire_s) begin
        wr_cnt_q <= wr_cnt_q + AW'(1);
      end
      if (wr_last_s) begin
        rd_page_q    <= wr_page_q;
        wr_page_q    <= ~wr_page_q;
        page_valid_q <= 1'b1;
        rd_n_q       <= n_lat_q;
      end
    end
  end

  // Banks below the base's bank hold lanes that spilled into the next row;
  // a row past the end wraps to 0 and the lane is rejected by the bound check.
  for (genvar k = 0; k < NCH; k++) begin : g_bank
    logic [RW-1:0] row_s;
    logic [AW:0]   elem_s;

    assign row_s  = rd_base_i[AW-1:BW] +
                    ((BW'(k) < rd_base_i[BW-1:0]) ? RW'(1) : RW'(0));
    assign elem_s = {1'b0, rd_base_i} + (AW+1)'(k);
    assign lane_ok_s[k] = page_valid_q && (elem_s < rd_n_q);

    vex_bank_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (RW + 1)
    ) u_ram (
      .clk_i   (clk_i),
      .we_i    (wr_fire_s && (wr_cnt_q[BW-1:0] == BW'(k))),
      .waddr_i ({wr_page_q, wr_cnt_q[AW-1:BW]}),
      .wdata_i (wr_data_i),
      .re_i    (rd_req_i),
      .raddr_i ({rd_page_q, row_s}),
      .rdata_o (bank_rdata_s[k])
    );
  end

  // Read stage 1: carry rotation and lane validity alongside the RAM read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q   <= 1'b0;
      rot1_q <= '0;
      ok1_q  <= '0;
    end else begin
      v1_q <= rd_req_i;
      if (rd_req_i) begin
        rot1_q <= rd_base_i[BW-1:0];
        ok1_q  <= lane_ok_s;
      end
    end
  end

  // Rotation crossbar with invalid lanes forced to zero.
  always_comb begin
    xbar_s = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ok1_q[c]) begin
        xbar_s[c*DATA_W +: DATA_W] =
          bank_rdata_s[BW'(lane_bank(32'(rot1_q), c, NCH))];
      end else begin
        xbar_s[c*DATA_W +: DATA_W] = '0;
      end
    end
  end

  // Read stage 2: registered outputs; data holds when no request completes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid_q   <= 1'b0;
      chan_data_q  <= '0;
      chan_valid_q <= '0;
    end else begin
      rd_valid_q <= v1_q;
      if (v1_q) begin
        chan_data_q  <= xbar_s;
        chan_valid_q <= ok1_q;
      end
    end
  end

  assign wr_ready_o   = wr_ready_s;
  assign fill_done_o  = fill_done_q;
  assign page_valid_o = page_valid_q;
  assign rd_valid_o   = rd_valid_q;
  assign chan_data_o  = chan_data_q;
  assign chan_valid_o = chan_valid_q;

endmodule

// File: tb/tb_vex_bank_xbar.sv
// Directed bench for vex_bank_xbar: fills, rotated reads, ping-pong swap,
// pipelined reads, count clamping, row wrap and reset mid-fill.
module tb_vex_bank_xbar;

  localparam int DATA_W = 64;
  localparam int NCH    = 4;
  localparam int DEPTH  = 8192;
  localparam int AW     = 13;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic                  start_i = 1'b0;
  logic [AW:0]           n_elem_i = '0;
  logic                  wr_valid_i = 1'b0;
  logic [DATA_W-1:0]     wr_data_i = '0;
  logic                  wr_ready_o, fill_done_o, page_valid_o, rd_valid_o;
  logic                  rd_req_i = 1'b0;
  logic [AW-1:0]         rd_base_i = '0;
  logic [NCH*DATA_W-1:0] chan_data_o;
  logic [NCH-1:0]        chan_valid_o;

  int passed = 0;
  int total  = 0;

  vex_bank_xbar #(.DATA_W(DATA_W), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .n_elem_i     (n_elem_i),
    .wr_valid_i   (wr_valid_i),
    .wr_data_i    (wr_data_i),
    .wr_ready_o   (wr_ready_o),
    .fill_done_o  (fill_done_o),
    .page_valid_o (page_valid_o),
    .rd_req_i     (rd_req_i),
    .rd_base_i    (rd_base_i),
    .rd_valid_o   (rd_valid_o),
    .chan_data_o  (chan_data_o),
    .chan_valid_o (chan_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [NCH*DATA_W-1:0] obs,
                     input logic [NCH*DATA_W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [NCH*DATA_W-1:0] lanes(input int a, input int b,
                                                  input int c, input int d);
    return {64'(d), 64'(c), 64'(b), 64'(a)};
  endfunction

  task automatic chk_out(input string tag, input logic [NCH*DATA_W-1:0] exp_d,
                         input logic [NCH-1:0] exp_v);
    chk({tag, ".rd_valid"}, rd_valid_o, 1);
    chk({tag, ".chan_valid"}, chan_valid_o, exp_v);
    chk({tag, ".chan_data"}, chan_data_o, exp_d);
  endtask

  task automatic rd(input int b);
    rd_req_i  = 1'b1;
    rd_base_i = AW'(b);
    tick();
    rd_req_i  = 1'b0;
    tick();
  endtask

  // Full fill of n_wr words valued base+e; optional idle gaps and a stray start.
  task automatic fill(input int n_req, input int n_wr, input int base,
                      input bit gaps, input bit mid_start);
    start_i  = 1'b1;
    n_elem_i = (AW+1)'(n_req);
    tick();
    start_i  = 1'b0;
    chk("fill.wr_ready", wr_ready_o, 1);
    for (int e = 0; e < n_wr; e++) begin
      if (gaps && (e % 3 == 1)) begin
        wr_valid_i = 1'b0;
        tick();
      end
      wr_valid_i = 1'b1;
      wr_data_i  = 64'(base + e);
      if (mid_start && e == 2) begin
        start_i  = 1'b1;
        n_elem_i = (AW+1)'(3);
      end
      tick();
      start_i = 1'b0;
      if (e == n_wr - 1 || n_wr < 64) chk("fill.fill_done", fill_done_o, (e == n_wr - 1));
    end
    wr_valid_i = 1'b0;
    chk("fill.wr_ready_end", wr_ready_o, 0);
    chk("fill.page_valid", page_valid_o, 1);
    tick();
    chk("fill.done_pulse", fill_done_o, 0);
  endtask

  initial begin
    // 1: reset state, read with no page
    tick();
    tick();
    rst_i = 1'b0;
    chk("rst.wr_ready", wr_ready_o, 0);
    chk("rst.page_valid", page_valid_o, 0);
    chk("rst.fill_done", fill_done_o, 0);
    chk("rst.rd_valid", rd_valid_o, 0);
    rd_req_i = 1'b1;
    rd_base_i = '0;
    tick();
    rd_req_i = 1'b0;
    chk("t1.latency1", rd_valid_o, 0);
    tick();
    chk_out("t1", '0, 4'b0000);
    tick();
    chk("t1.no_req", rd_valid_o, 0);

    // 2: 16 elements, rotated read
    fill(16, 16, 100, 1'b0, 1'b0);
    rd(5);
    chk_out("t2", lanes(105, 106, 107, 108), 4'b1111);

    // 3: partial page, bound masking
    fill(10, 10, 100, 1'b0, 1'b0);
    rd(8);
    chk_out("t3", lanes(108, 109, 0, 0), 4'b0011);

    // 4: ping-pong, read during fill and swap timing
    start_i = 1'b1;
    n_elem_i = (AW+1)'(16);
    tick();
    start_i = 1'b0;
    for (int e = 0; e < 15; e++) begin
      wr_valid_i = 1'b1;
      wr_data_i = 64'(200 + e);
      tick();
      if (e == 7) begin
        wr_valid_i = 1'b0;
        rd(0);
        chk_out("t4.during", lanes(100, 101, 102, 103), 4'b1111);
      end
    end
    wr_valid_i = 1'b1;
    wr_data_i = 64'(215);
    rd_req_i = 1'b1;
    rd_base_i = '0;
    tick();
    wr_valid_i = 1'b0;
    chk("t4.fill_done", fill_done_o, 1);
    tick();
    rd_req_i = 1'b0;
    chk_out("t4.old_page", lanes(100, 101, 102, 103), 4'b1111);
    tick();
    chk_out("t4.new_page", lanes(200, 201, 202, 203), 4'b1111);
    tick();

    // 5: back-to-back reads
    rd_req_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      rd_base_i = AW'(b);
      tick();
      if (b > 0) chk_out("t5.pipe", lanes(199 + b, 200 + b, 201 + b, 202 + b), 4'b1111);
    end
    rd_req_i = 1'b0;
    tick();
    chk_out("t5.last", lanes(203, 204, 205, 206), 4'b1111);
    tick();
    chk("t5.idle_valid", rd_valid_o, 0);
    chk("t5.hold", chan_data_o, lanes(203, 204, 205, 206));

    // 6: reset mid-fill and mid-read, then refill with gaps and a stray start
    start_i = 1'b1;
    n_elem_i = (AW+1)'(16);
    tick();
    start_i = 1'b0;
    for (int e = 0; e < 7; e++) begin
      wr_valid_i = 1'b1;
      wr_data_i = 64'(900 + e);
      rd_req_i = (e == 6);
      tick();
    end
    wr_valid_i = 1'b0;
    rd_req_i = 1'b0;
    rst_i = 1'b1;
    tick();
    chk("t6.rst_rd_valid", rd_valid_o, 0);
    rst_i = 1'b0;
    tick();
    chk("t6.flushed", rd_valid_o, 0);
    chk("t6.wr_ready", wr_ready_o, 0);
    chk("t6.page_valid", page_valid_o, 0);
    fill(8, 8, 300, 1'b1, 1'b1);
    rd(4);
    chk_out("t6.b4", lanes(304, 305, 306, 307), 4'b1111);
    rd(6);
    chk_out("t6.b6", lanes(306, 307, 0, 0), 4'b0011);

    // clamp low: n_elem=0 behaves as one element
    fill(0, 1, 500, 1'b0, 1'b0);
    rd(0);
    chk_out("clamp0", lanes(500, 0, 0, 0), 4'b0001);

    // clamp high and row wrap at the end of the page
    fill(9000, DEPTH, 0, 1'b0, 1'b0);
    rd(8188);
    chk_out("top.b8188", lanes(8188, 8189, 8190, 8191), 4'b1111);
    rd(8190);
    chk_out("wrap.b8190", lanes(8190, 8191, 0, 0), 4'b0011);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
